// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: game status and heading.
// Used by both the snake datapath and the game controller.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIE  = 2'b01,
    ST_PLAY = 2'b10,
    ST_OVER = 2'b11
  } game_status_e;

  // Bit 1 is the axis: 0 = vertical (UP/DOWN), 1 = horizontal (LEFT/RIGHT).
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam int CNT_W = 32;

  // A turn is legal only onto the other axis; reversals and same-axis presses are not.
  function automatic logic is_perpendicular(input dir_e a, input dir_e b);
    return a[1] != b[1];
  endfunction

endpackage

// File: rtl/turn_fifo.sv
// Two-entry turn queue. Entry 0 is the head; o_tail is the most recently
// written entry, which the controller uses to validate the next press.
module turn_fifo
  import snake_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_push,
  input  logic i_pop,
  input  dir_e i_din,
  output dir_e o_dout,
  output dir_e o_tail,
  output logic o_full,
  output logic o_empty
);

  dir_e       r_mem [2];
  logic [1:0] r_count;
  logic       w_do_pop;

  assign w_do_pop = i_pop && (r_count != 2'd0);

  // Shift-style storage: pop moves entry 1 down, push fills the first free slot.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the two entries are reset so o_tail/o_dout are never X; it is only four bits.
      r_mem[0] <= DIR_RIGHT;
      r_mem[1] <= DIR_RIGHT;
      r_count  <= 2'd0;
    end else if (i_clr) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_do_pop})
        2'b01: begin
          r_mem[0] <= r_mem[1];
          r_count  <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_mem[0] <= i_din;
            r_count  <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_mem[1] <= i_din;
            r_count  <= 2'd2;
          end
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_mem[0] <= i_din;
          end else begin
            r_mem[0] <= r_mem[1];
            r_mem[1] <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dout  = r_mem[0];
  assign o_tail  = (r_count == 2'd2) ? r_mem[1] : r_mem[0];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game controller: game FSM, step timer with speed-up per apple,
// buffered turn handling, score keeping and the death flash sequence.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned STEP_CYCLES   = 12500000,
  parameter int unsigned STEP_DEC      = 500000,
  parameter int unsigned MIN_STEP      = 3000000,
  parameter int unsigned FLASH_CYCLES  = 12500000,
  parameter int unsigned FLASH_TOGGLES = 6,
  parameter int unsigned MAX_LEN       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_press,
  input  logic       left_press,
  input  logic       right_press,
  input  logic       up_press,
  input  logic       down_press,
  input  logic       hit_wall,
  input  logic       hit_body,
  input  logic       apple_eaten,
  input  logic [6:0] body_num,
  output logic [1:0] game_status,
  output logic       step_tick,
  output logic [1:0] dir,
  output logic       add_length,
  output logic       die_flash,
  output logic [7:0] score
);

  localparam logic [CNT_W-1:0] P_INIT     = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] P_DEC      = CNT_W'(STEP_DEC);
  localparam logic [CNT_W-1:0] P_MIN      = CNT_W'(MIN_STEP);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [7:0]       TOG_LAST   = 8'(FLASH_TOGGLES - 1);
  localparam logic [6:0]       LEN_LIMIT  = 7'(MAX_LEN);

  game_status_e     r_state;
  dir_e             r_dir;
  logic [CNT_W-1:0] r_step_cnt;
  logic [CNT_W-1:0] r_cur_period;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_flash_cnt;
  logic [7:0]       r_toggle_cnt;
  logic [7:0]       r_score;
  logic             r_step_tick;
  logic             r_add_length;
  logic             r_die_flash;
  logic             r_apple_d;

  logic w_collide;
  logic w_in_play;
  logic w_accept_apple;
  logic w_step_term;
  logic w_flash_term;
  logic w_go_idle;
  logic w_press_any;
  dir_e w_press_dir;
  dir_e w_ref_dir;
  logic w_push;
  logic w_pop;
  dir_e w_fifo_dout;
  dir_e w_fifo_tail;
  logic w_fifo_full;
  logic w_fifo_empty;

  assign w_collide      = hit_wall | hit_body;
  assign w_in_play      = (r_state == ST_PLAY);
  assign w_accept_apple = w_in_play && apple_eaten && !r_apple_d && !w_collide;
  assign w_step_term    = (r_step_cnt == r_cur_period - CNT_W'(1));
  assign w_flash_term   = (r_flash_cnt == FLASH_LAST);
  assign w_go_idle      = (r_state == ST_OVER) && start_press;

  // Pick one press per cycle, left > right > up > down.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_press_any = left_press | right_press | up_press | down_press;
    w_press_dir = DIR_DOWN;
    if (left_press)       w_press_dir = DIR_LEFT;
    else if (right_press) w_press_dir = DIR_RIGHT;
    else if (up_press)    w_press_dir = DIR_UP;
  end

  // The last queued turn (or the current heading) is the reference. When a pop
  // coincides with a press, the post-pop tail is this same last-queued value.
  assign w_ref_dir = w_fifo_empty ? r_dir : w_fifo_tail;
  assign w_pop     = r_step_tick && !w_fifo_empty;
  assign w_push    = w_in_play && w_press_any && is_perpendicular(w_press_dir, w_ref_dir)
                     && (!w_fifo_full || w_pop);

  turn_fifo u_turn_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_go_idle),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_press_dir),
    .o_dout  (w_fifo_dout),
    .o_tail  (w_fifo_tail),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Heading changes only on a step, taking the next queued turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir <= DIR_RIGHT;
    end else if (w_go_idle) begin
      r_dir <= DIR_RIGHT;
    end else if (w_pop) begin
      r_dir <= w_fifo_dout;
    end
  end

  // Game FSM with step timer, apple scoring and death flash sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_step_cnt   <= '0;
      r_cur_period <= P_INIT;
      r_period     <= P_INIT;
      r_flash_cnt  <= '0;
      r_toggle_cnt <= '0;
      r_score      <= '0;
      r_step_tick  <= 1'b0;
      r_add_length <= 1'b0;
      r_die_flash  <= 1'b1;
      r_apple_d    <= 1'b0;
    end else begin
      r_apple_d    <= apple_eaten;
      r_step_tick  <= 1'b0;
      r_add_length <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_press) begin
            r_state      <= ST_PLAY;
            r_step_cnt   <= '0;
            r_cur_period <= r_period;
          end
        end
        ST_PLAY: begin
          if (w_collide) begin
            r_state      <= ST_DIE;
            r_step_cnt   <= '0;
            r_flash_cnt  <= '0;
            r_toggle_cnt <= '0;
            r_die_flash  <= 1'b1;
          end else begin
            if (w_step_term) begin
              r_step_cnt   <= '0;
              r_cur_period <= r_period;
              r_step_tick  <= 1'b1;
            end else begin
              r_step_cnt <= r_step_cnt + CNT_W'(1);
            end
            if (w_accept_apple) begin
              if (r_score != 8'hFF) r_score <= r_score + 8'd1;
              r_period     <= (r_period >= P_MIN + P_DEC) ? r_period - P_DEC : P_MIN;
              r_add_length <= (body_num < LEN_LIMIT);
            end
          end
        end
        ST_DIE: begin
          if (w_flash_term) begin
            r_flash_cnt <= '0;
            if (r_toggle_cnt == TOG_LAST) begin
              r_state      <= ST_OVER;
              r_toggle_cnt <= '0;
              r_die_flash  <= 1'b1;
            end else begin
              r_toggle_cnt <= r_toggle_cnt + 8'd1;
              r_die_flash  <= ~r_die_flash;
            end
          end else begin
            r_flash_cnt <= r_flash_cnt + CNT_W'(1);
          end
        end
        ST_OVER: begin
          if (start_press) begin
            r_state  <= ST_IDLE;
            r_score  <= '0;
            r_period <= P_INIT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign game_status = r_state;
  assign dir         = r_dir;
  assign step_tick   = r_step_tick;
  assign add_length  = r_add_length;
  assign die_flash   = r_die_flash;
  assign score       = r_score;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with small timing parameters.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_press = 1'b0;
  logic       left_press = 1'b0, right_press = 1'b0, up_press = 1'b0, down_press = 1'b0;
  logic       hit_wall = 1'b0, hit_body = 1'b0, apple_eaten = 1'b0;
  logic [6:0] body_num = 7'd5;
  logic [1:0] game_status, dir;
  logic       step_tick, add_length, die_flash;
  logic [7:0] score;

  int n_tests = 0;
  int n_fail  = 0;

  snake_game_ctrl #(
    .STEP_CYCLES  (10),
    .STEP_DEC     (2),
    .MIN_STEP     (4),
    .FLASH_CYCLES (3),
    .FLASH_TOGGLES(4),
    .MAX_LEN      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_press (start_press),
    .left_press  (left_press),
    .right_press (right_press),
    .up_press    (up_press),
    .down_press  (down_press),
    .hit_wall    (hit_wall),
    .hit_body    (hit_body),
    .apple_eaten (apple_eaten),
    .body_num    (body_num),
    .game_status (game_status),
    .step_tick   (step_tick),
    .dir         (dir),
    .add_length  (add_length),
    .die_flash   (die_flash),
    .score       (score)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic l, input logic r, input logic u, input logic d);
    left_press = l; right_press = r; up_press = u; down_press = d;
    @(negedge clk);
    left_press = 1'b0; right_press = 1'b0; up_press = 1'b0; down_press = 1'b0;
  endtask

  task automatic start_pulse();
    start_press = 1'b1;
    @(negedge clk);
    start_press = 1'b0;
  endtask

  task automatic apple_pulse();
    apple_eaten = 1'b1;
    @(negedge clk);
    apple_eaten = 1'b0;
  endtask

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!step_tick && cyc < 50);
    if (!step_tick) check("tick_timeout", {31'd0, step_tick}, 32'd1);
  endtask

  initial begin
    int c;
    int exp_period [3] = '{6, 4, 4};

    // Reset state
    step(3);
    check("rst_status", game_status, 0);
    check("rst_dir", dir, 3);
    check("rst_tick", step_tick, 0);
    check("rst_add", add_length, 0);
    check("rst_flash", die_flash, 1);
    check("rst_score", score, 0);
    rst = 1'b0;
    step(1);

    // Scenario 1: start, tick every 10 cycles
    start_pulse();
    check("s1_status", game_status, 2);
    wait_tick(c);
    check("s1_first_tick", c, 10);
    check("s1_dir", dir, 3);
    wait_tick(c);
    check("s1_period", c, 10);

    // Scenario 2: two queued turns, third press while full dropped
    step(1);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    press(0, 0, 0, 1);
    wait_tick(c); step(1);
    check("s2_dir_up", dir, 0);
    wait_tick(c); step(1);
    check("s2_dir_left", dir, 2);
    wait_tick(c); step(1);
    check("s2_full_drop", dir, 2);

    // Back to RIGHT via DOWN, then scenario 3: reverse press dropped
    press(0, 0, 0, 1);
    press(0, 1, 0, 0);
    wait_tick(c); step(1);
    check("s3_dir_down", dir, 1);
    wait_tick(c); step(1);
    check("s3_dir_right", dir, 3);
    press(1, 0, 0, 0);
    wait_tick(c); step(1);
    check("s3_reverse_drop", dir, 3);

    // Priority: up beats down, left beats right
    press(0, 0, 1, 1);
    wait_tick(c); step(1);
    check("prio_up_over_down", dir, 0);
    press(1, 1, 0, 0);
    wait_tick(c); step(1);
    check("prio_left_over_right", dir, 2);

    // Scenario 4: apples shorten the period 10->8->6->4->4
    apple_pulse();
    check("s4_add_1", add_length, 1);
    check("s4_score_1", score, 1);
    step(1);
    check("s4_add_pulse_end", add_length, 0);
    wait_tick(c);
    wait_tick(c);
    check("s4_period_8", c, 8);
    for (int i = 0; i < 3; i++) begin
      step(1);
      apple_pulse();
      check($sformatf("s4_add_%0d", i + 2), add_length, 1);
      check($sformatf("s4_score_%0d", i + 2), score, i + 2);
      wait_tick(c);
      wait_tick(c);
      check($sformatf("s4_period_%0d", exp_period[i]), c, exp_period[i]);
    end
    body_num = 7'd16;
    step(1);
    apple_pulse();
    check("s4_maxlen_score", score, 5);
    check("s4_maxlen_add", add_length, 0);
    step(1);
    check("s4_maxlen_add_late", add_length, 0);
    body_num = 7'd5;

    // Scenario 5: death flash, 4 toggles every 3 cycles, then OVER
    hit_body = 1'b1;
    @(negedge clk);
    hit_body = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      check($sformatf("s5_flash_%0d", k), die_flash,
            (k == 12) ? 1 : (((k / 3) % 2) == 0 ? 1 : 0));
      check($sformatf("s5_status_%0d", k), game_status, (k == 12) ? 3 : 1);
      if (k == 1) check("s5_no_tick_in_die", step_tick, 0);
      if (k < 12) step(1);
    end
    step(2);
    check("s5_over_hold", game_status, 3);
    press(0, 0, 1, 0);
    start_pulse();
    check("s5_idle", game_status, 0);
    check("s5_score_clr", score, 0);
    check("s5_dir_clr", dir, 3);

    // Scenario 6: IDLE press ignored, period restored, collision beats apple
    press(0, 0, 1, 0);
    start_pulse();
    check("s6_play", game_status, 2);
    wait_tick(c);
    check("s6_period_reset", c, 10);
    step(1);
    check("s6_idle_press_ignored", dir, 3);
    apple_pulse();
    check("s6_score_1", score, 1);
    step(1);
    hit_wall = 1'b1;
    apple_eaten = 1'b1;
    @(negedge clk);
    hit_wall = 1'b0;
    apple_eaten = 1'b0;
    check("s6_die", game_status, 1);
    check("s6_score_hold", score, 1);
    check("s6_no_add", add_length, 0);
    step(1);
    check("s6_no_add_late", add_length, 0);
    check("s6_score_hold_late", score, 1);
    step(3);
    check("s6_flash_low", die_flash, 0);

    // Reset mid-DIE aborts at once with no residual pulse
    rst = 1'b1;
    #1;
    check("s6_rst_status", game_status, 0);
    check("s6_rst_flash", die_flash, 1);
    step(2);
    rst = 1'b0;
    c = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (step_tick || add_length) c++;
    end
    check("s6_no_residual_pulse", c, 0);
    check("s6_post_rst_status", game_status, 0);
    check("s6_post_rst_score", score, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 Parameter STEP_CYCLES, default 12500000: initial cycles per snake step.
REQ-002 Parameter STEP_DEC, default 500000: step-period decrement per apple.
REQ-003 Parameter MIN_STEP, default 3000000: floor of the step period.
REQ-004 Parameter FLASH_CYCLES, default 12500000: cycles per die_flash half-period.
REQ-005 Parameter FLASH_TOGGLES, default 6: die_flash toggles before OVER.
REQ-006 Parameter MAX_LEN, default 16: snake length limit.
REQ-007 The ports SHALL be as follows; reset rst, asynchronous, active-high; clock clk:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start_press  in  1  start/restart pulse.
- left_press, right_press, up_press, down_press  in  1 each  direction pulses.
- hit_wall, hit_body  in  1 each  collision flags from the snake datapath.
- apple_eaten  in  1  level, high while the head is on the apple.
- body_num  in  7  current snake length.
- game_status  out  2  IDLE=00, DIE=01, PLAY=10, OVER=11.
- step_tick  out  1  one-cycle pulse that advances the snake.
- dir  out  2  UP=00, DOWN=01, LEFT=10, RIGHT=11.
- add_length  out  1  one-cycle grow pulse.
- die_flash  out  1  head/body visibility enable.
- score  out  8  apples eaten, saturating.

Function
REQ-008 The state machine SHALL follow these transitions: IDLE->PLAY on start_press; PLAY->DIE on (hit_wall|hit_body); DIE->OVER after FLASH_TOGGLES toggles of die_flash; OVER->IDLE on start_press; otherwise hold.
REQ-009 In PLAY, the step counter SHALL count 0..period-1 and pulse step_tick for one cycle at terminal count; step_tick SHALL be 0 in every other state, and the counter SHALL clear on any state change.
REQ-010 period SHALL reset to STEP_CYCLES and decrease by STEP_DEC per accepted apple, clamped at MIN_STEP; a new period SHALL take effect at the next counter restart.
REQ-011 Direction presses SHALL be arbitrated in priority left>right>up>down when several occur in one cycle.
REQ-012 A press SHALL be enqueued into a 2-entry turn FIFO only if it is perpendicular to the last enqueued direction (or to dir if the FIFO is empty); reverse and same-axis presses SHALL be dropped, as SHALL presses when the FIFO is full.
REQ-013 On step_tick the FIFO head SHALL pop into dir in the same cycle; dir SHALL change only on step_tick; a press coinciding with a pop SHALL be compared against the post-pop tail.
REQ-014 An apple SHALL be accepted on the rising edge of apple_eaten in PLAY: add_length pulses for one cycle the following cycle only if body_num<MAX_LEN; score increments, saturating at 255, regardless of length.
REQ-015 In IDLE, PLAY and OVER die_flash SHALL be 1; on entering DIE it SHALL toggle every FLASH_CYCLES cycles, starting from 1.
REQ-016 Collision during the same cycle as an apple edge: the collision SHALL win, with no score increment and no add_length.
REQ-017 Presses and apple edges outside PLAY SHALL be ignored; start_press in PLAY or DIE SHALL be ignored.
REQ-018 OVER->IDLE SHALL reset dir, period, score and the FIFO to their reset values.

Reset
REQ-019 On rst the block SHALL assert: game_status=IDLE, dir=RIGHT, step_tick=0, add_length=0, die_flash=1, score=0, period=STEP_CYCLES, FIFO empty, all counters 0.
REQ-020 rst asserted mid-DIE or mid-step SHALL abort immediately with no residual pulse after deassertion.

Structure
REQ-021 The direction and game_status encodings SHALL live in shared package snake_pkg, used by both the snake datapath and this block.
REQ-022 The 2-entry turn FIFO SHALL be a sub-module turn_fifo (push, pop, din, dout, tail, full, empty).

Verification
Scenarios use STEP_CYCLES=10, STEP_DEC=2, MIN_STEP=4, FLASH_CYCLES=3, FLASH_TOGGLES=4.
REQ-023 Scenario 1: rst, then start_press -> game_status=10, step_tick every 10 cycles, dir=11.
REQ-024 Scenario 2: in PLAY dir=RIGHT, up_press then left_press before a tick -> dir=UP at tick 1, LEFT at tick 2; a third press while full is dropped.
REQ-025 Scenario 3: left_press while dir=RIGHT -> dropped, dir stays 11.
REQ-026 Scenario 4: four apple edges -> score=4, period 10->8->6->4->4; with body_num=16, an edge gives score+1 and no add_length.
REQ-027 Scenario 5: hit_body -> game_status=01, die_flash toggles every 3 cycles, 4 toggles, then 11; start_press -> 00 with score=0.
REQ-028 Scenario 6: hit_wall and apple edge in the same cycle -> DIE, score unchanged; rst mid-DIE -> IDLE, die_flash=1.
